key_scan_encoder: RTL and testbench

KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

---
 rtl/key_scan_encoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_key_scan_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_encoder.sv
// Purpose : turns key press/release requests into PS/2 Set-2 make/break byte streams on a generated PS/2 clock/data pair.
// Latency : acceptance edge k -> start bit on ps2_data at k+1, first ps2_clk fall at k+1+CLK_DIV; 22*CLK_DIV cycles per byte.
// Backpress: req_ready low while a sequence is in flight; strobes seen then are dropped silently (no queueing).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   key_in       key index 0..9 (0 up,1 left,2 down,3 right,4 a,5 w,6 s,7 d,8 space,9 enter)
//   key_press    request make sequence for key_in
//   key_release  request break sequence for key_in
//   req_ready    high while idle; a request is taken on any edge where this is high
//   ps2_clk      generated PS/2 clock, idle high
//   ps2_data     PS/2 serial data, idle high
//   byte_done    one-cycle pulse after the stop bit of each byte
//   req_err      one-cycle pulse after a malformed request (both strobes, or key_in > 9)

module key_scan_encoder #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_HALVES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  input  logic       key_press,
  input  logic       key_release,
  output logic       req_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       byte_done,
  output logic       req_err
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALVES - 1);

  // Frame bit positions: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
  localparam logic [3:0] PAR_IDX  = 4'd9;
  localparam logic [3:0] STOP_IDX = 4'd10;

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [GW-1:0]   gap_cnt, gap_cnt_nx;
  logic [3:0]      bit_idx, bit_idx_nx;
  logic [1:0]      byte_idx, byte_idx_nx;

  // Request captured at acceptance; the sequence in flight only ever reads these.
  logic [3:0]      key_q;
  logic            brk_q;

  logic            strobe_any;
  logic            accept;
  logic            reject;
  logic            done_nx;

  logic [8:0]      code;
  logic [3:0][7:0] seq;
  logic [1:0]      last_byte;
  logic [7:0]      cur_byte;
  logic [2:0]      data_sel;
  logic            data_bit;
  logic            data_nx;

  // Set-2 scan codes; bit 8 marks keys that need the E0 prefix.
  function automatic logic [8:0] key_code(input logic [3:0] k);
    logic [8:0] c;
    case (k)
      4'd0:    c = 9'h175;
      4'd1:    c = 9'h16B;
      4'd2:    c = 9'h172;
      4'd3:    c = 9'h174;
      4'd4:    c = 9'h01C;
      4'd5:    c = 9'h01D;
      4'd6:    c = 9'h01B;
      4'd7:    c = 9'h023;
      4'd8:    c = 9'h029;
      4'd9:    c = 9'h05A;
      default: c = 9'h000;
    endcase
    return c;
  endfunction

  // Request qualification. Only one strobe with an in-range key is legal;
  // anything else seen while idle is flagged, anything seen while busy is dropped.
  always_comb begin
    strobe_any = key_press | key_release;
    accept     = (state == IDLE) && (key_press ^ key_release) && (key_in <= 4'd9);
    reject     = (state == IDLE) && strobe_any && !accept;
  end

  // Byte list for the latched request: [E0] [F0] code, with last_byte the
  // index of the final entry.
  always_comb begin
    code      = key_code(key_q);
    seq       = '0;
    last_byte = 2'd0;
    case ({code[8], brk_q})
      2'b00: begin
        seq[0]    = code[7:0];
        last_byte = 2'd0;
      end
      2'b01: begin
        seq[0]    = BRK_PREFIX;
        seq[1]    = code[7:0];
        last_byte = 2'd1;
      end
      2'b10: begin
        seq[0]    = EXT_PREFIX;
        seq[1]    = code[7:0];
        last_byte = 2'd1;
      end
      default: begin
        seq[0]    = EXT_PREFIX;
        seq[1]    = BRK_PREFIX;
        seq[2]    = code[7:0];
        last_byte = 2'd2;
      end
    endcase
  end

  // Next-state logic. The half-period counter reloads on every state change,
  // so each BIT_HI/BIT_LO lasts exactly CLK_DIV cycles and GAP lasts
  // GAP_HALVES such half-periods.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CW'(1);
    gap_cnt_nx  = gap_cnt;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx     = '0;
        gap_cnt_nx = '0;
        if (accept) begin
          state_nx    = BIT_HI;
          bit_idx_nx  = 4'd0;
          byte_idx_nx = 2'd0;
        end
      end

      BIT_HI: begin
        if (cnt == CNT_LAST) begin
          state_nx = BIT_LO;
          cnt_nx   = '0;
        end
      end

      BIT_LO: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (bit_idx == STOP_IDX) begin
            done_nx    = 1'b1;
            bit_idx_nx = 4'd0;
            if (byte_idx == last_byte) begin
              state_nx = IDLE;
            end else begin
              byte_idx_nx = byte_idx + 2'd1;
              gap_cnt_nx  = '0;
              state_nx    = (GAP_HALVES > 0) ? GAP : BIT_HI;
            end
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
            state_nx   = BIT_HI;
          end
        end
      end

      GAP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_nx = '0;
            state_nx   = BIT_HI;
          end else begin
            gap_cnt_nx = gap_cnt + GW'(1);
          end
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Line values for the next cycle. Data follows bit_idx_nx, which only
  // advances on BIT_LO->BIT_HI, so data moves while the clock is high and is
  // held across every falling edge. The start bit needs no byte value, so the
  // acceptance cycle is safe even though key_q is not yet loaded.
  always_comb begin
    cur_byte = seq[byte_idx_nx];
    data_sel = bit_idx_nx[2:0] - 3'd1;
    case (bit_idx_nx)
      4'd0:     data_bit = 1'b0;
      PAR_IDX:  data_bit = ~^cur_byte;
      STOP_IDX: data_bit = 1'b1;
      default:  data_bit = cur_byte[data_sel];
    endcase
    data_nx = ((state_nx == BIT_HI) || (state_nx == BIT_LO)) ? data_bit : 1'b1;
  end

  // Outputs are registered from the next-state decode so the PS/2 lines are
  // glitch-free and line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      bit_idx   <= 4'd0;
      byte_idx  <= 2'd0;
      key_q     <= 4'd0;
      brk_q     <= 1'b0;
      req_ready <= 1'b1;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      byte_done <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      bit_idx   <= bit_idx_nx;
      byte_idx  <= byte_idx_nx;
      if (accept) begin
        key_q <= key_in;
        brk_q <= key_release;
      end
      req_ready <= (state_nx == IDLE);
      ps2_clk   <= (state_nx != BIT_LO);
      ps2_data  <= data_nx;
      byte_done <= done_nx;
      req_err   <= reject;
    end
  end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Purpose : self-checking bench for key_scan_encoder (CLK_DIV=4, GAP_HALVES=2).
// Latency : checks start-bit timing, first clock fall, frame length and inter-byte gaps.
// Backpress: checks that strobes while busy are dropped and malformed ones flag req_err.

module tb_key_scan_encoder;

  localparam int CLK_DIV    = 4;
  localparam int GAP_HALVES = 2;
  localparam int FRAME_CYC  = 22 * CLK_DIV;
  localparam int GAP_CYC    = GAP_HALVES * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_in = 4'd0;
  logic       key_press = 1'b0;
  logic       key_release = 1'b0;
  logic       req_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       byte_done;
  logic       req_err;

  key_scan_encoder #(
    .CLK_DIV   (CLK_DIV),
    .GAP_HALVES(GAP_HALVES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_press  (key_press),
    .key_release(key_release),
    .req_ready  (req_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_done  (byte_done),
    .req_err    (req_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  // ---------------- line monitor: decodes frames from the PS/2 pins ----------------
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  int          nbits = 0;
  logic [10:0] fr = '0;
  logic [10:0] last_frame = '0;
  logic [7:0]  got[$];
  int          n_done = 0;
  int          n_err = 0;
  int          n_falls = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_clk && !ps2_clk) begin
        check("data_stable_at_fall", int'(ps2_data), int'(prev_data));
        fr[nbits] = ps2_data;
        nbits++;
        n_falls++;
        if (nbits == 11) begin
          check("start_bit", int'(fr[0]), 0);
          check("odd_parity", int'(^fr[9:1]), 1);
          check("stop_bit", int'(fr[10]), 1);
          got.push_back(fr[8:1]);
          last_frame = fr;
          nbits = 0;
        end
      end else if (!prev_clk && !ps2_clk) begin
        check("data_stable_clk_low", int'(ps2_data), int'(prev_data));
      end
      if (byte_done) n_done++;
      if (req_err) n_err++;
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  // ---------------- reference model: keys -> expected byte stream ----------------
  int        set2[10] = '{'h175, 'h16B, 'h172, 'h174, 'h01C, 'h01D, 'h01B, 'h023, 'h029, 'h05A};
  logic [7:0] exp_q[$];

  function automatic int model_request(input int k, input bit p, input bit r);
    // returns number of bytes expected; -1 means a req_err is expected
    int n;
    n = 0;
    if (!p && !r) return 0;
    if ((p && r) || k > 9) return -1;
    if (set2[k] >= 'h100) begin exp_q.push_back(8'hE0); n++; end
    if (r) begin exp_q.push_back(8'hF0); n++; end
    exp_q.push_back(8'(set2[k] & 'hFF));
    n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic run_req(input logic [3:0] k, input logic p, input logic r);
    @(negedge clk);
    key_in      = k;
    key_press   = p;
    key_release = r;
    @(negedge clk);
    key_press   = 1'b0;
    key_release = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    while (!req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(nm, int'(req_ready), 1);
  endtask

  task automatic check_bytes(input string nm, input int g0, input logic [23:0] bytes, input int nb);
    check({nm, "_count"}, got.size() - g0, nb);
    for (int i = 0; i < nb; i++) begin
      check({nm, "_byte"}, (g0 + i < got.size()) ? int'(got[g0 + i]) : -1,
            int'(bytes[23 - 8*i -: 8]));
    end
  endtask

  typedef struct {
    logic [3:0]  key;
    logic        press;
    logic        rel;
    int          nb;
    logic [23:0] bytes;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int g0, d0, e0, c, gl, f0, nb, exp_errs, exp_bytes;
    logic [10:0] exp_frame;
    logic [3:0]  rk;
    logic        rp, rr;

    vecs[0] = '{4'd4,  1'b1, 1'b0, 1, 24'h1C0000, 1'b0};
    vecs[1] = '{4'd0,  1'b0, 1'b1, 3, 24'hE0F075, 1'b0};
    vecs[2] = '{4'd9,  1'b1, 1'b0, 1, 24'h5A0000, 1'b0};
    vecs[3] = '{4'd1,  1'b1, 1'b0, 2, 24'hE06B00, 1'b0};
    vecs[4] = '{4'd8,  1'b0, 1'b1, 2, 24'hF02900, 1'b0};
    vecs[5] = '{4'd12, 1'b1, 1'b0, 0, 24'h000000, 1'b1};
    vecs[6] = '{4'd3,  1'b1, 1'b1, 0, 24'h000000, 1'b1};
    vecs[7] = '{4'd7,  1'b0, 1'b1, 2, 24'hF02300, 1'b0};
    vecs[8] = '{4'd5,  1'b1, 1'b0, 1, 24'h1D0000, 1'b0};
    vecs[9] = '{4'd15, 1'b0, 1'b1, 0, 24'h000000, 1'b1};

    // ---- reset state ----
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    check("rst_byte_done", int'(byte_done), 0);
    check("rst_req_err", int'(req_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ---- press 'a': latency, frame content, frame length ----
    g0 = got.size(); d0 = n_done;
    run_req(4'd4, 1'b1, 1'b0);
    check("lat_req_ready_low", int'(req_ready), 0);
    check("lat_start_bit", int'(ps2_data), 0);
    check("lat_clk_high", int'(ps2_clk), 1);
    c = 1;
    while (ps2_clk && c < 200) begin @(negedge clk); c++; end
    check("lat_first_fall", c, CLK_DIV + 1);
    while (!req_ready && c < 500) begin @(negedge clk); c++; end
    check("lat_back_to_idle", c - 1, FRAME_CYC);
    repeat (2) @(negedge clk);
    exp_frame = {1'b1, 1'b0, 8'h1C, 1'b0};
    check("a_frame_bits", int'(last_frame), int'(exp_frame));
    check_bytes("a_press", g0, 24'h1C0000, 1);
    check("a_byte_done", n_done - d0, 1);

    // ---- release 'up': three bytes with idle gaps between them ----
    g0 = got.size(); d0 = n_done;
    run_req(4'd0, 1'b0, 1'b1);
    for (int gi = 0; gi < 2; gi++) begin
      c = 0;
      while (!byte_done && c < 400) begin @(negedge clk); c++; end
      check("gap_byte_done_seen", int'(byte_done), 1);
      gl = 0;
      while (ps2_data && ps2_clk && gl < 100) begin gl++; @(negedge clk); end
      check("gap_len", gl, GAP_CYC);
    end
    wait_ready("up_rel_ready");
    repeat (2) @(negedge clk);
    check_bytes("up_release", g0, 24'hE0F075, 3);
    check("up_byte_done", n_done - d0, 3);

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      g0 = got.size(); d0 = n_done; e0 = n_err;
      run_req(vecs[i].key, vecs[i].press, vecs[i].rel);
      if (vecs[i].err) begin
        check($sformatf("vec%0d_ready_held", i), int'(req_ready), 1);
        check($sformatf("vec%0d_clk_idle", i), int'(ps2_clk), 1);
        check($sformatf("vec%0d_data_idle", i), int'(ps2_data), 1);
      end
      wait_ready($sformatf("vec%0d_ready", i));
      repeat (2) @(negedge clk);
      check_bytes($sformatf("vec%0d", i), g0, vecs[i].bytes, vecs[i].nb);
      check($sformatf("vec%0d_done", i), n_done - d0, vecs[i].nb);
      check($sformatf("vec%0d_err", i), n_err - e0, int'(vecs[i].err));
    end

    // ---- strobes mid-frame are ignored; key_in change after acceptance has no effect ----
    g0 = got.size(); d0 = n_done; e0 = n_err;
    run_req(4'd2, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    key_in = 4'd12; key_press = 1'b1;
    @(negedge clk);
    key_press = 1'b0; key_in = 4'd5;
    repeat (30) @(negedge clk);
    key_press = 1'b1; key_release = 1'b1;
    @(negedge clk);
    key_press = 1'b0; key_release = 1'b0;
    wait_ready("busy_ready");
    repeat (2) @(negedge clk);
    check_bytes("busy_down", g0, 24'hE07200, 2);
    check("busy_no_err", n_err - e0, 0);
    check("busy_done", n_done - d0, 2);

    // ---- reset after the 5th clock fall aborts the frame ----
    g0 = got.size(); d0 = n_done;
    f0 = n_falls;
    run_req(4'd6, 1'b1, 1'b0);
    c = 0;
    while (n_falls - f0 < 5 && c < 400) begin @(negedge clk); c++; end
    check("abort_5_falls", n_falls - f0, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_clk_high", int'(ps2_clk), 1);
    check("abort_data_high", int'(ps2_data), 1);
    check("abort_ready", int'(req_ready), 1);
    nbits = 0;
    repeat (100) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_byte", got.size() - g0, 0);
    run_req(4'd8, 1'b1, 1'b0);
    wait_ready("abort_recover_ready");
    repeat (2) @(negedge clk);
    check_bytes("abort_recover", g0, 24'h290000, 1);

    // ---- back-to-back: new press on the cycle req_ready rises ----
    g0 = got.size();
    run_req(4'd7, 1'b1, 1'b0);
    c = 0;
    while (!req_ready && c < 400) begin @(negedge clk); c++; end
    key_in = 4'd1; key_press = 1'b1;
    @(negedge clk);
    key_press = 1'b0;
    check("b2b_accepted", int'(req_ready), 0);
    check("b2b_start_bit", int'(ps2_data), 0);
    wait_ready("b2b_ready");
    repeat (2) @(negedge clk);
    check_bytes("b2b", g0, 24'h23E06B, 3);

    // ---- randomized requests against the reference model ----
    exp_q.delete();
    g0 = got.size(); d0 = n_done; e0 = n_err;
    exp_errs = 0; exp_bytes = 0;
    for (int it = 0; it < 24; it++) begin
      rk = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       begin rp = 1'b1; rr = 1'b0; end
        1:       begin rp = 1'b0; rr = 1'b1; end
        2:       begin rp = 1'b1; rr = 1'b1; end
        default: begin rp = 1'b0; rr = 1'b0; end
      endcase
      nb = model_request(int'(rk), rp, rr);
      if (nb < 0) exp_errs++;
      else exp_bytes += nb;
      run_req(rk, rp, rr);
      if (nb > 0 && $urandom_range(0, 1) == 1) begin
        repeat (20) @(negedge clk);
        key_in = 4'($urandom_range(0, 15));
        key_press = 1'b1;
        key_release = 1'($urandom_range(0, 1));
        @(negedge clk);
        key_press = 1'b0; key_release = 1'b0;
      end
      wait_ready("rnd_ready");
      repeat (2) @(negedge clk);
    end
    check("rnd_byte_count", got.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check("rnd_byte", (g0 + i < got.size()) ? int'(got[g0 + i]) : -1, int'(exp_q[i]));
    end
    check("rnd_done", n_done - d0, exp_bytes);
    check("rnd_err", n_err - e0, exp_errs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
